// File: rtl/nibble_serial_adder_ctrl.sv
// Wide adder that reuses one 4-bit ripple slice over WIDTH/4 cycles with a start/busy/done handshake.
// Optional subtract path is enabled by defining SUB_EN.
module nibble_serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NIB - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t           state_r, state_s;
  logic [WIDTH-1:0] a_sh_r, a_sh_s, b_sh_r, b_sh_s, acc_r, acc_s;
  logic [WIDTH-1:0] result_r, result_s, b_eff_s;
  logic [CW-1:0]    cnt_r, cnt_s;
  logic             carry_r, carry_s, cin_eff_s;
  logic             cout_r, cout_s, ovf_r, ovf_s, busy_r, done_r;
  logic [4:0]       slice_s;

  // Shared FA_4 slice: bit-by-bit ripple, returns {carry_out, sum[3:0]}
  function automatic logic [4:0] fa4(input logic [3:0] x, input logic [3:0] y, input logic ci);
    logic [4:0] r;
    logic       c;
    c = ci;
    for (int i = 0; i < 4; i++) begin
      r[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    r[4] = c;
    return r;
  endfunction

`ifdef SUB_EN
  assign b_eff_s   = op ? ~b : b;
  assign cin_eff_s = op ? 1'b1 : cin;
`else
  logic unused_op_s;
  assign b_eff_s     = b;
  assign cin_eff_s   = cin;
  assign unused_op_s = op;
`endif

  // Next-state and datapath: one nibble per RUN cycle, outputs captured on the final pass
  always_comb begin
    state_s  = state_r;
    a_sh_s   = a_sh_r;
    b_sh_s   = b_sh_r;
    acc_s    = acc_r;
    carry_s  = carry_r;
    cnt_s    = cnt_r;
    result_s = result_r;
    cout_s   = cout_r;
    ovf_s    = ovf_r;
    slice_s  = fa4(a_sh_r[3:0], b_sh_r[3:0], carry_r);
    case (state_r)
      IDLE: begin
        if (start) begin
          a_sh_s  = a;
          b_sh_s  = b_eff_s;
          carry_s = cin_eff_s;
          acc_s   = {WIDTH{1'b0}};
          cnt_s   = {CW{1'b0}};
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        acc_s   = {slice_s[3:0], acc_r[WIDTH-1:4]};
        carry_s = slice_s[4];
        a_sh_s  = a_sh_r >> 3'd4;
        b_sh_s  = b_sh_r >> 3'd4;
        cnt_s   = cnt_r + CNT_ONE;
        if (cnt_r == CNT_LAST) begin
          // On the last pass the low nibble holds the operands' top bits
          state_s  = DONE;
          result_s = acc_s;
          cout_s   = slice_s[4];
          ovf_s    = (a_sh_r[3] == b_sh_r[3]) && (slice_s[3] != a_sh_r[3]);
        end else begin
          state_s = RUN;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State, datapath and registered handshake outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= IDLE;
      a_sh_r   <= {WIDTH{1'b0}};
      b_sh_r   <= {WIDTH{1'b0}};
      acc_r    <= {WIDTH{1'b0}};
      carry_r  <= 1'b0;
      cnt_r    <= {CW{1'b0}};
      result_r <= {WIDTH{1'b0}};
      cout_r   <= 1'b0;
      ovf_r    <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      a_sh_r   <= a_sh_s;
      b_sh_r   <= b_sh_s;
      acc_r    <= acc_s;
      carry_r  <= carry_s;
      cnt_r    <= cnt_s;
      result_r <= result_s;
      cout_r   <= cout_s;
      ovf_r    <= ovf_s;
      busy_r   <= (state_s == RUN);
      done_r   <= (state_s == DONE);
    end
  end

  assign busy   = busy_r;
  assign done   = done_r;
  assign result = result_r;
  assign cout   = cout_r;
  assign ovf    = ovf_r;

endmodule
